// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and width helpers for the D-stage hazard scoreboard.
// Imported by the interface, the per-port selector and the top level.
package hazard_pkg;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         REG_W        = 5;
  localparam int         FSEL_GRF     = 0;
  localparam int         MULT_CYC_DEF = 5;
  localparam int         DIV_CYC_DEF  = 10;

  // One scoreboard entry is {valid, a3, tnew}.
  function automatic int entry_width(input int tw);
    return 1 + REG_W + tw;
  endfunction

  // Forward-select code: 0 = GRF, k+1 = stage k, so it must encode NSTAGE+1 values.
  function automatic int sel_width(input int nstage);
    return $clog2(nstage + 1);
  endfunction

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage operand/hazard bundle between the pipeline (master) and the
// hazard scoreboard (slave).
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int NSTAGE = 3,
  parameter int NPORT  = 2,
  parameter int TW     = 2
);

  localparam int SW = sel_width(NSTAGE);

  logic                  d_valid;
  logic [4:0]            d_a3;
  logic [TW-1:0]         d_tnew;
  logic [NPORT*5-1:0]    d_rs;
  logic [NPORT*TW-1:0]   d_tuse;
  logic [NPORT*32-1:0]   d_rd;
  logic [NSTAGE*32-1:0]  stage_wd;
  logic                  md_start;
  logic                  md_is_div;
  logic                  d_md_use;
  logic                  stall;
  logic [NPORT*32-1:0]   fwd_data;
  logic [NPORT*SW-1:0]   fwd_sel;
  logic                  md_busy;

  modport master (
    output d_valid, d_a3, d_tnew, d_rs, d_tuse, d_rd, stage_wd,
           md_start, md_is_div, d_md_use,
    input  stall, fwd_data, fwd_sel, md_busy
  );

  modport slave (
    input  d_valid, d_a3, d_tnew, d_rs, d_tuse, d_rd, stage_wd,
           md_start, md_is_div, d_md_use,
    output stall, fwd_data, fwd_sel, md_busy
  );

endinterface

// File: rtl/hazard_scoreboard_fwd_port_sel.sv
// Youngest-writer search, readiness test and stall/forward decision for a
// single D-stage read port.
module fwd_port_sel
  import hazard_pkg::*;
#(
  parameter  int NSTAGE = 3,
  parameter  int TW     = 2,
  localparam int EW     = entry_width(TW),
  localparam int SW     = sel_width(NSTAGE)
) (
  input  logic [NSTAGE*EW-1:0] entries,
  input  logic [4:0]           rs,
  input  logic [TW-1:0]        tuse,
  input  logic [31:0]          rd,
  input  logic [NSTAGE*32-1:0] stage_wd,
  output logic                 stall,
  output logic [SW-1:0]        sel,
  output logic [31:0]          data
);

  typedef struct packed {
    logic          valid;
    logic [4:0]    a3;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t cur;
  entry_t hit;
  logic   found;
  int     idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    cur   = '0;
    hit   = '0;
    found = 1'b0;
    idx   = 0;
    stall = 1'b0;
    sel   = SW'(FSEL_GRF);
    data  = rd;
    // Scan oldest to youngest so the youngest match overwrites older ones.
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      cur = entry_t'(entries[k*EW +: EW]);
      if (cur.valid && (cur.a3 == rs) && (rs != REG_ZERO)) begin
        found = 1'b1;
        idx   = k;
        hit   = cur;
      end
    end
    if (found) begin
      stall = (hit.tnew > tuse);
      if (hit.tnew == '0) begin
        sel  = SW'(idx + 1);
        data = stage_wd[idx*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight GPR writers E..W plus mult/div occupancy,
// and produces the D-stage stall and per-port forwarded operands.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE   = 3,
  parameter int NPORT    = 2,
  parameter int TW       = 2,
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);

  localparam int EW = entry_width(TW);
  localparam int SW = sel_width(NSTAGE);
  localparam int CW = cnt_width(MULT_CYC, DIV_CYC);

  typedef struct packed {
    logic          valid;
    logic [4:0]    a3;
    logic [TW-1:0] tnew;
  } entry_t;

  entry_t                 entry_q [NSTAGE];
  logic [NSTAGE*EW-1:0]   entry_flat;
  logic [CW-1:0]          md_cnt;
  logic                   md_busy;
  logic                   stall;
  logic [NPORT-1:0]       port_stall;
  logic [SW-1:0]          port_sel  [NPORT];
  logic [31:0]            port_data [NPORT];

  function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its predecessor's pre-edge value and the shift is order-independent.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NSTAGE; k++) entry_q[k] <= '0;
      md_cnt <= '0;
    end else begin
      // A stalled D slot becomes a bubble in E; older stages keep draining.
      if (stall) entry_q[0] <= '0;
      else       entry_q[0] <= '{valid: hz.d_valid && (hz.d_a3 != REG_ZERO),
                                 a3:    hz.d_a3,
                                 tnew:  hz.d_tnew};
      for (int k = 1; k < NSTAGE; k++) begin
        entry_q[k] <= '{valid: entry_q[k-1].valid,
                        a3:    entry_q[k-1].a3,
                        tnew:  tnew_dec(entry_q[k-1].tnew)};
      end
      // A new start always reloads, even over a countdown in progress.
      if (hz.md_start)       md_cnt <= hz.md_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
      else if (md_cnt != '0) md_cnt <= md_cnt - CW'(1);
    end
  end

  always_comb begin
    entry_flat = '0;
    for (int k = 0; k < NSTAGE; k++) entry_flat[k*EW +: EW] = entry_q[k];
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fwd_port_sel #(
      .NSTAGE (NSTAGE),
      .TW     (TW)
    ) u_sel (
      .entries  (entry_flat),
      .rs       (hz.d_rs[5*p +: 5]),
      .tuse     (hz.d_tuse[TW*p +: TW]),
      .rd       (hz.d_rd[32*p +: 32]),
      .stage_wd (hz.stage_wd),
      .stall    (port_stall[p]),
      .sel      (port_sel[p]),
      .data     (port_data[p])
    );
  end

  assign md_busy = hz.md_start || (md_cnt != '0);
  assign stall   = (|port_stall) || (hz.d_md_use && md_busy);

  always_comb begin
    hz.fwd_sel  = '0;
    hz.fwd_data = '0;
    for (int p = 0; p < NPORT; p++) begin
      hz.fwd_sel[SW*p +: SW]  = port_sel[p];
      hz.fwd_data[32*p +: 32] = port_data[p];
    end
  end

  assign hz.stall   = stall;
  assign hz.md_busy = md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a driver queues expected outputs per
// cycle, a negedge monitor pops and compares them against the DUT.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam logic [31:0] RD0 = 32'hAAAA_0000;
  localparam logic [31:0] RD1 = 32'hBBBB_1111;
  localparam logic [31:0] W0  = 32'hE0E0_E0E0;
  localparam logic [31:0] W1  = 32'hDEAD_BEEF;
  localparam logic [31:0] W2  = 32'h1234_5678;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NSTAGE(3), .NPORT(2), .TW(2)) hz_a ();
  hazard_scoreboard_if #(.NSTAGE(4), .NPORT(3), .TW(2)) hz_b ();

  hazard_scoreboard #(.NSTAGE(3), .NPORT(2), .TW(2), .MULT_CYC(5), .DIV_CYC(10)) dut_a (
    .clk (clk), .reset (reset), .hz (hz_a.slave));
  hazard_scoreboard #(.NSTAGE(4), .NPORT(3), .TW(2), .MULT_CYC(5), .DIV_CYC(10)) dut_b (
    .clk (clk), .reset (reset), .hz (hz_b.slave));

  typedef struct {
    int          stamp;
    string       name;
    bit          is_b;
    logic        stall;
    logic        busy;
    logic [95:0] sel;
    logic [95:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   total   = 0;
  int   bad     = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string n, input logic st, input logic bz,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.stamp = cyc_cnt; e.name = n; e.is_b = 1'b0; e.stall = st; e.busy = bz;
    e.sel   = {92'b0, s1, s0};
    e.data  = {32'b0, d1, d0};
    exp_q.push_back(e);
  endtask

  task automatic exp_b(input string n, input logic st, input logic [8:0] s);
    exp_t e;
    e.stamp = cyc_cnt; e.name = n; e.is_b = 1'b1; e.stall = st; e.busy = 1'b0;
    e.sel   = {87'b0, s};
    e.data  = '0;
    exp_q.push_back(e);
  endtask

  task automatic set_d(input logic v, input logic [4:0] a3, input logic [1:0] tn);
    hz_a.d_valid = v; hz_a.d_a3 = a3; hz_a.d_tnew = tn;
  endtask

  task automatic set_rs(input logic [4:0] r0, input logic [1:0] t0,
                        input logic [4:0] r1, input logic [1:0] t1);
    hz_a.d_rs = {r1, r0}; hz_a.d_tuse = {t1, t0};
  endtask

  // Monitor: compares whatever expectation the driver queued for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, ".cycle"}, 96'(cyc_cnt), 96'(mon_e.stamp));
        if (!mon_e.is_b) begin
          check({mon_e.name, ".stall"}, 96'(hz_a.stall),    96'(mon_e.stall));
          check({mon_e.name, ".busy"},  96'(hz_a.md_busy),  96'(mon_e.busy));
          check({mon_e.name, ".sel"},   96'(hz_a.fwd_sel),  mon_e.sel);
          check({mon_e.name, ".data"},  96'(hz_a.fwd_data), mon_e.data);
        end else begin
          check({mon_e.name, ".stall"}, 96'(hz_b.stall),    96'(mon_e.stall));
          check({mon_e.name, ".sel"},   96'(hz_b.fwd_sel),  mon_e.sel);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    set_d(1'b0, 5'd0, 2'd0);
    set_rs(5'd0, 2'd0, 5'd0, 2'd0);
    hz_a.d_rd = {RD1, RD0}; hz_a.stage_wd = {W2, W1, W0};
    hz_a.md_start = 1'b0; hz_a.md_is_div = 1'b0; hz_a.d_md_use = 1'b0;
    hz_b.d_valid = 1'b0; hz_b.d_a3 = 5'd0; hz_b.d_tnew = 2'd0;
    hz_b.d_rs = '0; hz_b.d_tuse = '0;
    hz_b.d_rd = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    hz_b.stage_wd = {32'hB3B3_B3B3, 32'hB2B2_B2B2, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
    hz_b.md_start = 1'b0; hz_b.md_is_div = 1'b0; hz_b.d_md_use = 1'b0;
    tick(); tick();
    reset = 1'b0;
    exp_a("reset", 0, 0, 0, 0, RD0, RD1); tick();

    // Load-use: lw $3 (tnew 2) followed by a tuse-0 reader.
    set_d(1, 5'd3, 2'd2); exp_a("lw_issue", 0, 0, 0, 0, RD0, RD1); tick();
    set_d(0, 0, 0); set_rs(5'd3, 2'd0, 5'd0, 2'd0);
    exp_a("lw_stall1", 1, 0, 0, 0, RD0, RD1); tick();
    exp_a("lw_stall2", 1, 0, 0, 0, RD0, RD1); tick();
    exp_a("lw_fwd_w",  0, 0, 3, 0, W2, RD1);  tick();
    set_rs(5'd0, 2'd0, 5'd0, 2'd0);
    exp_a("lw_done",   0, 0, 0, 0, RD0, RD1); tick();

    // ALU result consumed late enough: no stall, forwarded from M.
    set_d(1, 5'd5, 2'd1); exp_a("addu_issue", 0, 0, 0, 0, RD0, RD1); tick();
    set_d(0, 0, 0); set_rs(5'd5, 2'd1, 5'd0, 2'd0);
    exp_a("addu_e_nostall", 0, 0, 0, 0, RD0, RD1); tick();
    exp_a("addu_fwd_m",     0, 0, 2, 0, W1, RD1);  tick();

    // Duplicate $7 in E and M: the E copy is forwarded.
    set_rs(5'd0, 2'd0, 5'd0, 2'd0);
    set_d(1, 5'd7, 2'd1); exp_a("dup_issue1", 0, 0, 0, 0, RD0, RD1); tick();
    set_d(1, 5'd7, 2'd0); exp_a("dup_issue2", 0, 0, 0, 0, RD0, RD1); tick();
    set_d(1, 5'd0, 2'd0); set_rs(5'd7, 2'd0, 5'd0, 2'd0);
    exp_a("dup_e_wins", 0, 0, 1, 0, W0, RD1); tick();
    set_d(0, 0, 0); set_rs(5'd0, 2'd0, 5'd0, 2'd0);
    exp_a("rs_zero", 0, 0, 0, 0, RD0, RD1); tick();

    // Young unready $9 in E shadows a ready $9 in M (read on port 1).
    set_d(1, 5'd9, 2'd1); exp_a("shadow_issue1", 0, 0, 0, 0, RD0, RD1); tick();
    set_d(1, 5'd9, 2'd2); exp_a("shadow_issue2", 0, 0, 0, 0, RD0, RD1); tick();
    set_d(0, 0, 0); set_rs(5'd0, 2'd0, 5'd9, 2'd0);
    exp_a("shadow_stall", 1, 0, 0, 0, RD0, RD1); tick();
    set_rs(5'd0, 2'd0, 5'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      exp_a($sformatf("drain_%0d", i), 0, 0, 0, 0, RD0, RD1); tick();
    end

    // Divide then mflo: start cycle + 10 busy cycles.
    hz_a.md_start = 1; hz_a.md_is_div = 1; hz_a.d_md_use = 1;
    for (int i = 0; i < 12; i++) begin
      exp_a($sformatf("div_%0d", i), i < 11, i < 11, 0, 0, RD0, RD1); tick();
      hz_a.md_start = 0;
    end
    // Multiply: start cycle + 5 busy cycles.
    hz_a.md_start = 1; hz_a.md_is_div = 0;
    for (int i = 0; i < 8; i++) begin
      exp_a($sformatf("mult_%0d", i), i < 6, i < 6, 0, 0, RD0, RD1); tick();
      hz_a.md_start = 0;
    end
    hz_a.d_md_use = 0;

    // Reset mid-divide with 4 cycles left, while lw $3 is in flight.
    hz_a.md_start = 1; hz_a.md_is_div = 1;
    exp_a("rdiv_start", 0, 1, 0, 0, RD0, RD1); tick();
    hz_a.md_start = 0;
    for (int i = 1; i < 6; i++) begin
      exp_a($sformatf("rdiv_run_%0d", i), 0, 1, 0, 0, RD0, RD1); tick();
    end
    set_d(1, 5'd3, 2'd2); exp_a("rdiv_lw", 0, 1, 0, 0, RD0, RD1); tick();
    set_d(0, 0, 0); reset = 1'b1;
    exp_a("rdiv_reset", 0, 1, 0, 0, RD0, RD1); tick();
    reset = 1'b0; set_rs(5'd3, 2'd0, 5'd0, 2'd0);
    exp_a("post_reset", 0, 0, 0, 0, RD0, RD1); tick();
    set_rs(5'd0, 2'd0, 5'd0, 2'd0);

    // Wide build: two ports hazard on $11 (tnew 2) and $10 (tnew 3).
    hz_b.d_valid = 1; hz_b.d_a3 = 5'd11; hz_b.d_tnew = 2'd2;
    exp_b("b_issue11", 0, 9'd0); tick();
    hz_b.d_a3 = 5'd10; hz_b.d_tnew = 2'd3;
    exp_b("b_issue10", 0, 9'd0); tick();
    hz_b.d_valid = 0; hz_b.d_a3 = 5'd0; hz_b.d_tnew = 2'd0;
    hz_b.d_rs = {5'd0, 5'd11, 5'd10}; hz_b.d_tuse = '0;
    exp_b("b_both",  1, 9'd0);  tick();
    exp_b("b_slow1", 1, 9'd24); tick();
    exp_b("b_slow2", 1, 9'd32); tick();
    exp_b("b_clear", 0, 9'd4);  tick();

    tick(); tick();
    check("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline forwarding unit. Keeps its own shift-register scoreboard of in-flight writers ({valid, A3, Tnew} per stage E..W) and a mult/div busy counter. From these it produces the decode-stage stall and the forwarded operand data for each read port. It sits beside the D stage, and its stall output freezes PC/F-D and inserts a bubble into D-E.

Parameters:
NSTAGE, 3, tracked stages after D (0=E, 1=M, 2=W)
NPORT, 2, operand read ports at D
TW, 2, Tnew/Tuse width
MULT_CYC, 5, busy cycles for mult/multu
DIV_CYC, 10, busy cycles for div/divu

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
d_valid  in  1  D instruction writes a GPR
d_a3  in  5  D destination register
d_tnew  in  TW  D result latency, counted at entry to E
d_rs  in  NPORT*5  source register per port, port p at [5p+4:5p]
d_tuse  in  NPORT*TW  cycles until port p value is consumed
d_rd  in  NPORT*32  raw GRF read data per port
stage_wd  in  NSTAGE*32  result bus of stage k at [32k+31:32k]
md_start  in  1  mult/div instruction is in E this cycle
md_is_div  in  1  qualifies md_start
d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
stall  out  1  freeze F/D, bubble into E
fwd_data  out  NPORT*32  forwarded operand per port
fwd_sel  out  NPORT*2  0=GRF, k+1=stage k (debug/coverage)
md_busy  out  1  mult/div unit occupied

Behaviour:
- Single clock domain. All state updates on the rising edge of clk.
- reset is synchronous and active-high. While it is asserted, every entry valid=0, A3=0, Tnew=0, and the md counter = 0. After reset, outputs are combinational on that state: stall=0 unless an input condition holds, md_busy=0, fwd_sel=0, fwd_data=d_rd.
- Scoreboard shift, every edge:
  - entry0 <= stall ? bubble : {d_valid && d_a3!=0, d_a3, d_tnew}
  - entry k (k>0) <= entry k-1 with Tnew decremented, saturating at 0. No stall freeze applies beyond E.
- Tnew also decrements on the entry0 -> entry1 move.
- A stage counts as "ready" when its entry is valid and Tnew==0. stage_wd[k] is trusted only when stage k is ready.
- Per-port match: only the youngest stage (lowest k) whose valid A3 == d_rs[p] is considered. Older matches are shadowed by it.
- d_rs[p]==0 never matches, never stalls, and returns d_rd.
- Per-port stall: a youngest match with Tnew > d_tuse[p].
- Per-port forward:
  - Youngest match is ready: fwd_sel = k+1, fwd_data = stage_wd[k].
  - Otherwise: fwd_sel = 0, fwd_data = d_rd[p].
  - This covers the W-stage same-cycle write with no reliance on GRF internal bypass.
- Mult/div:
  - On md_start, counter <= md_is_div ? DIV_CYC : MULT_CYC.
  - Otherwise counter decrements while nonzero.
  - md_busy = md_start || counter!=0.
  - An md_start that arrives while the counter is nonzero reloads the counter.
- stall = OR of per-port stalls, OR (d_md_use && md_busy). Purely combinational, so there is zero-cycle latency.
- Boundaries:
  - When the stall condition persists, a bubble enters E each cycle until it clears.
  - Duplicate A3 in E and M: E wins.
  - Tnew already 0 stays 0.
  - Reset asserted mid-mult aborts the countdown; md_busy=0 the next cycle.

Decomposition:
- Package hazard_pkg holds:
  - REG_ZERO
  - FSEL_GRF
  - entry struct/width constant (1+5+TW)
  - default MULT_CYC and DIV_CYC
- One sub-module, fwd_port_sel, is instantiated NPORT times. It does the youngest-match search, the ready test and the stall/forward decision for one port.
- The top level owns the shift register, the md counter and the OR reductions.

Test Plan:
- lw $3 issued (d_a3=3, d_tnew=2). Next cycle D has rs=$3, tuse=0 -> stall=1 for exactly 2 cycles. Then fwd_sel=3 (W) and fwd_data = stage_wd[2] = 0x1234_5678.
- addu $5 (tnew=1), then D with rs=$5, tuse=1 -> stall=0. fwd_sel=2 (M) the next cycle with fwd_data = stage_wd[1] = 0xDEAD_BEEF.
- E and M both write $7. D reads $7 with E ready -> fwd_sel=1, M data ignored. Also rs=$0 with E writing d_a3=0 -> fwd_sel=0, d_rd returned.
- md_start with md_is_div=1, then mflo in D -> stall=1 for 11 cycles (start cycle + 10), 0 after. The mult variant gives 6 cycles.
- reset asserted for 1 cycle mid-div with 4 cycles left -> md_busy=0 and all entries invalid on the next cycle. A D read of $3 then shows stall=0, fwd_data=d_rd.
- Port 0 and port 1 both hazard on different registers with differing Tnew -> stall holds until the slower one clears. Check with NPORT=3, NSTAGE=4 build.
